// File: rtl/ncpu32k_imem_resp.sv
// ncpu32k_imem_resp
//   Responder end of the instruction bus. Accepts fetch commands (valid/ready
//   plus byte address), reads a synchronous instruction memory with 1-cycle
//   latency, and returns {insn, address-as-id} in command order through a
//   DEPTH-entry response FIFO. Supports backpressure and flush.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ibus_cmd_valid    command present
//   ibus_cmd_ready    command accepted this cycle (combinational)
//   ibus_cmd_addr     fetch byte address (word aligned)
//   ibus_flush        drop all buffered and in-flight responses
//   ibus_dout_valid   response present (registered)
//   ibus_dout_ready   consumer takes response this cycle
//   ibus_dout         instruction word (registered FIFO head)
//   ibus_out_id       byte address of the instruction (registered FIFO head)
//   mem_en            memory read strobe (combinational, equals accept)
//   mem_addr          memory word address (combinational)
//   mem_rdata         memory data, valid the cycle after mem_en

module ncpu32k_imem_resp #(
   parameter int unsigned AW    = 32,
   parameter int unsigned IW    = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ibus_cmd_valid,
   output logic          ibus_cmd_ready,
   input  logic [AW-1:0] ibus_cmd_addr,
   input  logic          ibus_flush,
   output logic          ibus_dout_valid,
   input  logic          ibus_dout_ready,
   output logic [IW-1:0] ibus_dout,
   output logic [AW-1:0] ibus_out_id,
   output logic          mem_en,
   output logic [AW-3:0] mem_addr,
   input  logic [IW-1:0] mem_rdata
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   // FIFO bookkeeping and the read in flight
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic          pend_vld;
   logic [AW-1:0] pend_addr;

   // FIFO storage (contents are don't-care until written)
   logic [AW-1:0] fifo_addr [DEPTH];
   logic [IW-1:0] fifo_insn [DEPTH];

   // Registered response outputs
   logic          dout_valid_q;
   logic [IW-1:0] dout_q;
   logic [AW-1:0] id_q;

   // Next-state signals
   logic          pop;
   logic          acc;
   logic          push;
   logic [CW-1:0] occ;
   logic [PW-1:0] rd_ptr_nxt;
   logic [PW-1:0] wr_ptr_nxt;
   logic [CW-1:0] cnt_nxt;
   logic [IW-1:0] head_insn_nxt;
   logic [AW-1:0] head_addr_nxt;

   // Handshakes; pop term lets a full FIFO accept while draining
   always_comb begin
      pop            = ibus_dout_valid & ibus_dout_ready;
      occ            = cnt + CW'(pend_vld);
      ibus_cmd_ready = ~rst & ~ibus_flush & ((occ < CW'(DEPTH)) | pop);
      acc            = ibus_cmd_valid & ibus_cmd_ready;
      push           = pend_vld;
      mem_en         = acc;
      mem_addr       = ibus_cmd_addr[AW-1:2];
   end

   // Pointer/count update and the head value to present next cycle
   always_comb begin
      rd_ptr_nxt    = rd_ptr + PW'(pop);
      wr_ptr_nxt    = wr_ptr + PW'(push);
      cnt_nxt       = cnt + CW'(push) - CW'(pop);
      head_insn_nxt = fifo_insn[rd_ptr_nxt];
      head_addr_nxt = fifo_addr[rd_ptr_nxt];
      // Entry being written this cycle becomes the head: bypass into the output register
      if (push && (wr_ptr == rd_ptr_nxt)) begin
         head_insn_nxt = mem_rdata;
         head_addr_nxt = pend_addr;
      end
   end

   // Control state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         cnt          <= '0;
         pend_vld     <= 1'b0;
         pend_addr    <= '0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
         id_q         <= '0;
      end else if (ibus_flush) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         cnt          <= '0;
         pend_vld     <= 1'b0;
         dout_valid_q <= 1'b0;
      end else begin
         rd_ptr       <= rd_ptr_nxt;
         wr_ptr       <= wr_ptr_nxt;
         cnt          <= cnt_nxt;
         pend_vld     <= acc;
         dout_valid_q <= (cnt_nxt != '0);
         dout_q       <= head_insn_nxt;
         id_q         <= head_addr_nxt;
         if (acc) begin
            pend_addr <= ibus_cmd_addr;
         end
      end
   end

   // FIFO storage write; a write during flush/reset is harmless since pointers clear
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= pend_addr;
         fifo_insn[wr_ptr] <= mem_rdata;
      end
   end

   always_comb begin
      ibus_dout_valid = dout_valid_q;
      ibus_dout       = dout_q;
      ibus_out_id     = id_q;
   end

`ifdef NCPU_ENABLE_ASSERT
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (acc && (ibus_cmd_addr[1:0] != 2'b00)) begin
            $fatal(1, "ncpu32k_imem_resp: unaligned fetch address %h", ibus_cmd_addr);
         end
         if (occ > CW'(DEPTH)) begin
            $fatal(1, "ncpu32k_imem_resp: occupancy %0d exceeds DEPTH", occ);
         end
      end
   end
`endif

endmodule

// File: tb/tb_ncpu32k_imem_resp.sv
// Bench for ncpu32k_imem_resp: directed scenarios plus a random run, with an
// in-order scoreboard filled on command accept and drained on response pop.

module tb_ncpu32k_imem_resp;

   localparam int unsigned AW    = 32;
   localparam int unsigned IW    = 32;
   localparam int unsigned DEPTH = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [IW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          ibus_cmd_valid;
   logic          ibus_cmd_ready;
   logic [AW-1:0] ibus_cmd_addr;
   logic          ibus_flush;
   logic          ibus_dout_valid;
   logic          ibus_dout_ready;
   logic [IW-1:0] ibus_dout;
   logic [AW-1:0] ibus_out_id;
   logic          mem_en;
   logic [AW-3:0] mem_addr;
   logic [IW-1:0] mem_rdata = '0;

   logic [IW-1:0] tbmem [1024];
   exp_t          sb_q [$];
   exp_t          e;
   int            vec  = 0;
   int            miss = 0;

   logic          m_pop, m_acc, m_clr;
   logic          chk_hold = 1'b0;
   logic [IW-1:0] prev_dout;
   logic [AW-1:0] prev_id;

   ncpu32k_imem_resp #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .ibus_cmd_valid  (ibus_cmd_valid),
      .ibus_cmd_ready  (ibus_cmd_ready),
      .ibus_cmd_addr   (ibus_cmd_addr),
      .ibus_flush      (ibus_flush),
      .ibus_dout_valid (ibus_dout_valid),
      .ibus_dout_ready (ibus_dout_ready),
      .ibus_dout       (ibus_dout),
      .ibus_out_id     (ibus_out_id),
      .mem_en          (mem_en),
      .mem_addr        (mem_addr),
      .mem_rdata       (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory with one cycle of read latency
   always @(posedge clk) begin
      if (mem_en === 1'b1) mem_rdata <= tbmem[mem_addr[9:0]];
   end

   // Scoreboard monitor: order/data on every pop, hold rule, occupancy bound
   always @(negedge clk) begin
      m_pop = (ibus_dout_valid === 1'b1) && (ibus_dout_ready === 1'b1);
      m_acc = (ibus_cmd_valid === 1'b1) && (ibus_cmd_ready === 1'b1);
      m_clr = (rst === 1'b1) || (ibus_flush === 1'b1);
      if (chk_hold) begin
         vec++;
         if (ibus_dout_valid !== 1'b1 || ibus_dout !== prev_dout || ibus_out_id !== prev_id) begin
            miss++;
            $display("FAIL hold: valid=%b dout=%h id=%h, required valid=1 dout=%h id=%h",
                     ibus_dout_valid, ibus_dout, ibus_out_id, prev_dout, prev_id);
         end
      end
      if (m_pop) begin
         vec++;
         if (sb_q.size() == 0) begin
            miss++;
            $display("FAIL sb_unexpected: got id=%h dout=%h, required no response", ibus_out_id, ibus_dout);
         end else begin
            e = sb_q.pop_front();
            if (ibus_out_id !== e.addr || ibus_dout !== e.data) begin
               miss++;
               $display("FAIL sb_resp: got id=%h dout=%h, required id=%h dout=%h",
                        ibus_out_id, ibus_dout, e.addr, e.data);
            end
         end
      end
      if (m_clr) sb_q.delete();
      if (m_acc) sb_q.push_back('{addr: ibus_cmd_addr, data: tbmem[ibus_cmd_addr[11:2]]});
      vec++;
      if (sb_q.size() > DEPTH) begin
         miss++;
         $display("FAIL outstanding: got %0d, required <= %0d", sb_q.size(), DEPTH);
      end
      chk_hold  = (ibus_dout_valid === 1'b1) && !m_pop && !m_clr;
      prev_dout = ibus_dout;
      prev_id   = ibus_out_id;
   end

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic rd, input logic fl, input logic r);
      @(posedge clk);
      #1;
      ibus_cmd_valid  = v;
      ibus_cmd_addr   = a;
      ibus_dout_ready = rd;
      ibus_flush      = fl;
      rst             = r;
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
         vec++;
         if (ibus_cmd_ready !== 1'b0 || mem_en !== 1'b0) begin
            miss++;
            $display("FAIL reset_ready: cmd_ready=%b mem_en=%b, required 0 0", ibus_cmd_ready, mem_en);
         end
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_dout_valid !== 1'b0 || ibus_cmd_ready !== 1'b1 || ibus_dout !== '0 || ibus_out_id !== '0) begin
         miss++;
         $display("FAIL reset_state: valid=%b ready=%b dout=%h id=%h, required 0 1 0 0",
                  ibus_dout_valid, ibus_cmd_ready, ibus_dout, ibus_out_id);
      end
   endtask

   task automatic test_single();
      drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_cmd_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 30'h10) begin
         miss++;
         $display("FAIL single_cmd: ready=%b mem_en=%b mem_addr=%h, required 1 1 10",
                  ibus_cmd_ready, mem_en, mem_addr);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_dout_valid !== 1'b0) begin
         miss++;
         $display("FAIL single_t1: valid=%b, required 0", ibus_dout_valid);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_dout_valid !== 1'b1 || ibus_dout !== 32'hDEADBEEF || ibus_out_id !== 32'h40) begin
         miss++;
         $display("FAIL single_t2: valid=%b dout=%h id=%h, required 1 deadbeef 00000040",
                  ibus_dout_valid, ibus_dout, ibus_out_id);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_dout_valid !== 1'b0) begin
         miss++;
         $display("FAIL single_t3: valid=%b, required 0", ibus_dout_valid);
      end
   endtask

   task automatic test_stream();
      for (int c = 0; c < 20; c++) begin
         drive(c < 16, AW'(c * 4), 1'b1, 1'b0, 1'b0);
         if (c < 16) begin
            vec++;
            if (ibus_cmd_ready !== 1'b1) begin
               miss++;
               $display("FAIL stream_ready: cycle %0d ready=%b, required 1", c, ibus_cmd_ready);
            end
         end
         if (c >= 2 && c < 18) begin
            vec++;
            if (ibus_dout_valid !== 1'b1 || ibus_out_id !== AW'((c - 2) * 4)) begin
               miss++;
               $display("FAIL stream_resp: cycle %0d valid=%b id=%h, required 1 %h",
                        c, ibus_dout_valid, ibus_out_id, AW'((c - 2) * 4));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] a = 32'h200;
      int            n = 0;
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, a, 1'b0, 1'b0, 1'b0);
         if (ibus_cmd_ready === 1'b1) begin
            n++;
            a += 4;
         end
      end
      vec++;
      if (n != DEPTH || ibus_cmd_ready !== 1'b0 || ibus_out_id !== 32'h200) begin
         miss++;
         $display("FAIL bp_fill: accepts=%0d ready=%b head=%h, required %0d 0 00000200",
                  n, ibus_cmd_ready, ibus_out_id, DEPTH);
      end
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, a, 1'b1, 1'b0, 1'b0);
         vec++;
         if (ibus_cmd_ready !== 1'b1) begin
            miss++;
            $display("FAIL bp_release: cycle %0d ready=%b, required 1", c, ibus_cmd_ready);
         end
         if (ibus_cmd_ready === 1'b1) a += 4;
      end
      for (int c = 0; c < 4; c++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      vec++;
      if (sb_q.size() != 0 || ibus_dout_valid !== 1'b0) begin
         miss++;
         $display("FAIL bp_drain: left=%0d valid=%b, required 0 0", sb_q.size(), ibus_dout_valid);
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h308, 1'b0, 1'b1, 1'b0);
      vec++;
      if (ibus_cmd_ready !== 1'b0 || mem_en !== 1'b0 || ibus_dout_valid !== 1'b1) begin
         miss++;
         $display("FAIL flush_cycle: ready=%b mem_en=%b valid=%b, required 0 0 1",
                  ibus_cmd_ready, mem_en, ibus_dout_valid);
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
         vec++;
         if (ibus_dout_valid !== 1'b0) begin
            miss++;
            $display("FAIL flush_after: cycle %0d valid=%b id=%h, required valid 0", c, ibus_dout_valid, ibus_out_id);
         end
      end
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_dout_valid !== 1'b1 || ibus_dout !== 32'hCAFEF00D || ibus_out_id !== 32'h100) begin
         miss++;
         $display("FAIL flush_resume: valid=%b dout=%h id=%h, required 1 cafef00d 00000100",
                  ibus_dout_valid, ibus_dout, ibus_out_id);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 32'h180, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h184, 1'b1, 1'b0, 1'b1);
      vec++;
      if (ibus_cmd_ready !== 1'b0 || mem_en !== 1'b0) begin
         miss++;
         $display("FAIL rstmid_cycle: ready=%b mem_en=%b, required 0 0", ibus_cmd_ready, mem_en);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_dout_valid !== 1'b0 || ibus_cmd_ready !== 1'b1 || ibus_dout !== '0 || ibus_out_id !== '0) begin
         miss++;
         $display("FAIL rstmid_state: valid=%b ready=%b dout=%h id=%h, required 0 1 0 0",
                  ibus_dout_valid, ibus_cmd_ready, ibus_dout, ibus_out_id);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_dout_valid !== 1'b0) begin
         miss++;
         $display("FAIL rstmid_drop: valid=%b id=%h, required valid 0", ibus_dout_valid, ibus_out_id);
      end
      drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vec++;
      if (ibus_dout_valid !== 1'b1 || ibus_dout !== 32'hDEADBEEF || ibus_out_id !== 32'h40) begin
         miss++;
         $display("FAIL rstmid_resume: valid=%b dout=%h id=%h, required 1 deadbeef 00000040",
                  ibus_dout_valid, ibus_dout, ibus_out_id);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 10000; c++) begin
         drive($urandom_range(0, 9) < 7, {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
               $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, 1'b0);
      end
      for (int c = 0; c < 8; c++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      vec++;
      if (sb_q.size() != 0 || ibus_dout_valid !== 1'b0) begin
         miss++;
         $display("FAIL random_drain: left=%0d valid=%b, required 0 0", sb_q.size(), ibus_dout_valid);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) tbmem[i] = $urandom;
      tbmem[16'h10] = 32'hDEADBEEF;
      tbmem[16'h40] = 32'hCAFEF00D;
      rst             = 1'b1;
      ibus_cmd_valid  = 1'b0;
      ibus_cmd_addr   = '0;
      ibus_flush      = 1'b0;
      ibus_dout_ready = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
